// File: rtl/core_seq_ctrl_pkg.sv
// Shared instruction-bus layout and state encodings for the tiled-convolution sequencer.
// core and corelet decode inst with the same bit positions.
package core_seq_ctrl_pkg;

  localparam int unsigned InstW     = 36;
  localparam int unsigned InstAddrW = 11;

  localparam int unsigned InstLoadBit     = 0;
  localparam int unsigned InstExecBit     = 1;
  localparam int unsigned InstL0WrBit     = 2;
  localparam int unsigned InstL0RdBit     = 3;
  localparam int unsigned InstIfifoWrBit  = 4;
  localparam int unsigned InstIfifoRdBit  = 5;
  localparam int unsigned InstOfifoRdBit  = 6;
  localparam int unsigned InstModeBit     = 7;
  localparam int unsigned InstAXmemLsb    = 8;
  localparam int unsigned InstAXmemMsb    = 18;
  localparam int unsigned InstWenXmemBit  = 19;
  localparam int unsigned InstCenXmemBit  = 20;
  localparam int unsigned InstAPmemLsb    = 21;
  localparam int unsigned InstAPmemMsb    = 31;
  localparam int unsigned InstWenPmemBit  = 32;
  localparam int unsigned InstCenPmemBit  = 33;
  localparam int unsigned InstAccBit      = 34;

  typedef struct packed {
    logic                 reserved;
    logic                 acc;
    logic                 cen_pmem;
    logic                 wen_pmem;
    logic [InstAddrW-1:0] a_pmem;
    logic                 cen_xmem;
    logic                 wen_xmem;
    logic [InstAddrW-1:0] a_xmem;
    logic                 mode;
    logic                 ofifo_rd;
    logic                 ififo_rd;
    logic                 ififo_wr;
    logic                 l0_rd;
    logic                 l0_wr;
    logic                 execute;
    logic                 load;
  } core_inst_t;

  // Both memories deselected and write-disabled; everything else low.
  localparam logic [InstW-1:0] InstIdle = 36'h3_0018_0000;

  typedef enum logic [2:0] {
    StIdle,
    StWRd,
    StWLd,
    StXRd,
    StExec,
    StDrain,
    StDone
  } seq_state_e;

  typedef enum logic {
    DrRd,
    DrWr
  } drain_state_e;

endpackage

// File: rtl/psum_drain_ctrl.sv
// OFIFO-to-pmem drain: read/write handshake with ofifo_valid, pmem address counter and
// acc generation. Pulses drain_done on the write of the last psum word.
module psum_drain_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  ofifo_valid,
  input  logic                  acc_en,
  input  logic [addr_width-1:0] nij,
  input  logic [addr_width-1:0] p_base,
  output logic                  ofifo_rd,
  output logic                  pmem_cen,
  output logic                  pmem_wen,
  output logic                  acc,
  output logic [addr_width-1:0] pmem_addr,
  output logic                  drain_done
);

  drain_state_e          st_q, st_d;
  logic [addr_width-1:0] n_q, n_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= DrRd;
      n_q  <= '0;
    end else begin
      st_q <= st_d;
      n_q  <= n_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    n_d        = n_q;
    ofifo_rd   = 1'b0;
    pmem_cen   = 1'b1;
    pmem_wen   = 1'b1;
    acc        = 1'b0;
    pmem_addr  = '0;
    drain_done = 1'b0;
    if (!en) begin
      st_d = DrRd;
      n_d  = '0;
    end else begin
      unique case (st_q)
        // A stall simply holds here with the bus idle and n unchanged.
        DrRd: begin
          if (ofifo_valid) begin
            ofifo_rd  = 1'b1;
            pmem_cen  = 1'b0;
            acc       = acc_en;
            pmem_addr = p_base + n_q;
            st_d      = DrWr;
          end
        end
        DrWr: begin
          pmem_cen  = 1'b0;
          pmem_wen  = 1'b0;
          acc       = acc_en;
          pmem_addr = p_base + n_q;
          st_d      = DrRd;
          if (n_q == nij - 1'b1) begin
            n_d        = '0;
            drain_done = 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Sequencer driving core's 36-bit inst bus: per kernel position it loads weights, streams
// activations, executes and drains psums into pmem (accumulating after the first pass).
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned row        = 8,
  parameter int unsigned col        = 8,
  parameter int unsigned addr_width = 11,
  parameter int unsigned kij_w      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] cfg_nij,
  input  logic [kij_w-1:0]      cfg_kij,
  input  logic [addr_width-1:0] cfg_w_base,
  input  logic [addr_width-1:0] cfg_x_base,
  input  logic [addr_width-1:0] cfg_p_base,
  input  logic                  ofifo_valid,
  output logic [InstW-1:0]      inst,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so the X_RD count can reach nij itself.
  localparam int unsigned CntW = addr_width + 1;

  seq_state_e            st_q, st_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [kij_w-1:0]      k_q, k_d;
  logic [kij_w-1:0]      kij_q;
  logic [addr_width-1:0] nij_q, w_base_q, x_base_q, p_base_q;
  logic [addr_width-1:0] w_ofs;
  core_inst_t            inst_q, inst_d;

  logic                  dr_ofifo_rd, dr_cen, dr_wen, dr_acc, dr_done;
  logic [addr_width-1:0] dr_addr;

  assign w_ofs = addr_width'(32'(k_q) * row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      k_q      <= '0;
      inst_q   <= InstIdle;
      kij_q    <= '0;
      nij_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      inst_q <= inst_d;
      if (st_q == StIdle && start) begin
        kij_q    <= cfg_kij;
        nij_q    <= cfg_nij;
        w_base_q <= cfg_w_base;
        x_base_q <= cfg_x_base;
        p_base_q <= cfg_p_base;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    inst_d = InstIdle;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          k_d   = '0;
          cnt_d = '0;
          st_d  = (cfg_nij == '0 || cfg_kij == '0) ? StDone : StWRd;
        end
      end
      // l0_wr trails each read by one cycle to cover the SRAM Q latency.
      StWRd: begin
        if (cnt_q < CntW'(row)) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = w_base_q + w_ofs + cnt_q[addr_width-1:0];
        end
        inst_d.l0_wr = (cnt_q != '0);
        if (cnt_q == CntW'(row)) begin
          cnt_d = '0;
          st_d  = StWLd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // First row cycles load weights, the next col cycles flush the array.
      StWLd: begin
        if (cnt_q < CntW'(row)) begin
          inst_d.l0_rd = 1'b1;
          inst_d.load  = 1'b1;
        end
        if (cnt_q == CntW'(row + col - 1)) begin
          cnt_d = '0;
          st_d  = StXRd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXRd: begin
        if (cnt_q < CntW'(nij_q)) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = x_base_q + cnt_q[addr_width-1:0];
        end
        inst_d.l0_wr = (cnt_q != '0);
        if (cnt_q == CntW'(nij_q)) begin
          cnt_d = '0;
          st_d  = StExec;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (cnt_q == CntW'(nij_q) - 1'b1) begin
          cnt_d = '0;
          st_d  = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        inst_d.ofifo_rd = dr_ofifo_rd;
        inst_d.cen_pmem = dr_cen;
        inst_d.wen_pmem = dr_wen;
        inst_d.a_pmem   = dr_addr;
        inst_d.acc      = dr_acc;
        if (dr_done) begin
          k_d   = k_q + 1'b1;
          cnt_d = '0;
          st_d  = (k_q + 1'b1 == kij_q) ? StDone : StWRd;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  psum_drain_ctrl #(
    .addr_width(addr_width)
  ) u_drain (
    .clk        (clk),
    .reset      (reset),
    .en         (st_q == StDrain),
    .ofifo_valid(ofifo_valid),
    .acc_en     (k_q != '0),
    .nij        (nij_q),
    .p_base     (p_base_q),
    .ofifo_rd   (dr_ofifo_rd),
    .pmem_cen   (dr_cen),
    .pmem_wen   (dr_wen),
    .acc        (dr_acc),
    .pmem_addr  (dr_addr),
    .drain_done (dr_done)
  );

  assign inst = inst_q;
  assign busy = (st_q != StIdle) && (st_q != StDone);
  assign done = (st_q == StDone);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: table of run configurations with hand-computed totals,
// plus hand sequences for reset, drain stall, abort/rerun and address wrap.
module tb_core_seq_ctrl;

  localparam logic [35:0] IdleC = 36'h3_0018_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] cfg_nij, cfg_w_base, cfg_x_base, cfg_p_base;
  logic [3:0]  cfg_kij;
  logic        ofifo_valid;
  logic [35:0] inst;
  logic        busy, done;

  core_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_nij    (cfg_nij),
    .cfg_kij    (cfg_kij),
    .cfg_w_base (cfg_w_base),
    .cfg_x_base (cfg_x_base),
    .cfg_p_base (cfg_p_base),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Observed activity, accumulated forever; runs compare deltas from a snapshot.
  int          m_busy = 0, m_done = 0, m_xrd = 0, m_pacc = 0, m_pwr = 0, m_acc1 = 0;
  int          m_load = 0, m_exec = 0, m_l0wr = 0;
  logic [10:0] xq[$];
  logic [10:0] pq[$];
  logic        aq[$];

  always @(negedge clk) begin
    if (busy) m_busy <= m_busy + 1;
    if (done) m_done <= m_done + 1;
    if (!inst[20]) begin
      m_xrd <= m_xrd + 1;
      xq.push_back(inst[18:8]);
    end
    if (!inst[33]) m_pacc <= m_pacc + 1;
    if (!inst[33] && !inst[32]) begin
      m_pwr <= m_pwr + 1;
      pq.push_back(inst[31:21]);
      aq.push_back(inst[34]);
      if (inst[34]) m_acc1 <= m_acc1 + 1;
    end
    if (inst[0]) m_load <= m_load + 1;
    if (inst[1]) m_exec <= m_exec + 1;
    if (inst[2]) m_l0wr <= m_l0wr + 1;
  end

  typedef struct {
    int nij, kij, wb, xb, pb, mid;
    int busy, xrd, fx, lx, pacc, pwr, acc1, load, exec, l0wr, dn;
  } vec_t;

  vec_t tbl[7];
  int   ncmp = 0, nbad = 0;
  int   b_busy, b_done, b_xrd, b_pacc, b_pwr, b_acc1, b_load, b_exec, b_l0wr, bx, bp;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic snap();
    b_busy = m_busy; b_done = m_done; b_xrd = m_xrd; b_pacc = m_pacc; b_pwr = m_pwr;
    b_acc1 = m_acc1; b_load = m_load; b_exec = m_exec; b_l0wr = m_l0wr;
    bx = xq.size(); bp = pq.size();
  endtask

  task automatic kick(input int nij, kij, wb, xb, pb);
    @(posedge clk); #1;
    cfg_nij = 11'(nij); cfg_kij = 4'(kij);
    cfg_w_base = 11'(wb); cfg_x_base = 11'(xb); cfg_p_base = 11'(pb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (m_done == b_done && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (m_done == b_done) chk({nm, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string nm, input vec_t v);
    snap();
    kick(v.nij, v.kij, v.wb, v.xb, v.pb);
    if (v.mid != 0) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(nm);
    chk({nm, "_busy"}, m_busy - b_busy, v.busy);
    chk({nm, "_xrd"}, m_xrd - b_xrd, v.xrd);
    chk({nm, "_first_x"}, (xq.size() > bx) ? xq[bx] : 0, v.fx);
    chk({nm, "_last_x"}, (xq.size() > bx) ? xq[xq.size()-1] : 0, v.lx);
    chk({nm, "_pacc"}, m_pacc - b_pacc, v.pacc);
    chk({nm, "_pwr"}, m_pwr - b_pwr, v.pwr);
    chk({nm, "_acc1"}, m_acc1 - b_acc1, v.acc1);
    chk({nm, "_load"}, m_load - b_load, v.load);
    chk({nm, "_exec"}, m_exec - b_exec, v.exec);
    chk({nm, "_l0wr"}, m_l0wr - b_l0wr, v.l0wr);
    chk({nm, "_done"}, m_done - b_done, v.dn);
    chk({nm, "_end_inst"}, inst, IdleC);
  endtask

  initial begin
    //        nij kij  wb    xb    pb  mid busy xrd  fx    lx  pacc pwr acc1 load exec l0wr dn
    tbl[0] = '{4, 1, 0,    16,   0,    0, 42,  12, 0,    19,   8,  4,  0,  8,  4,  12, 1};
    tbl[1] = '{4, 1, 0,    16,   0,    1, 42,  12, 0,    19,   8,  4,  0,  8,  4,  12, 1};
    tbl[2] = '{2, 3, 100,  50,   0,    0, 102, 30, 100,  51,   12, 6,  4,  24, 6,  30, 1};
    tbl[3] = '{0, 2, 5,    5,    5,    0, 0,   0,  0,    0,    0,  0,  0,  0,  0,  0,  1};
    tbl[4] = '{3, 0, 5,    5,    5,    0, 0,   0,  0,    0,    0,  0,  0,  0,  0,  0,  1};
    tbl[5] = '{1, 1, 2044, 2046, 2047, 0, 30,  9,  2044, 2046, 2,  1,  0,  8,  1,  9,  1};
    tbl[6] = '{3, 2, 0,    0,    20,   0, 76,  22, 0,    2,    12, 6,  3,  16, 6,  22, 1};

    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
    cfg_nij = '0; cfg_kij = '0; cfg_w_base = '0; cfg_x_base = '0; cfg_p_base = '0;

    // Reset held, then released with start low.
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, IdleC);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_inst", inst, IdleC);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
    end

    for (int i = 0; i < 7; i++) run_case($sformatf("vec%0d", i), tbl[i]);

    // Three passes: weights at 100/108/116, pmem 0,1 rewritten with acc only after pass 0.
    run_case("pass3", tbl[2]);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("pass3_w%0d_%0d", k, i), xq[bx + k*10 + i], 100 + k*8 + i);
      chk($sformatf("pass3_x%0d", k), xq[bx + k*10 + 8], 50);
      chk($sformatf("pass3_pa%0d", k), pq[bp + k*2], 0);
      chk($sformatf("pass3_pb%0d", k), pq[bp + k*2 + 1], 1);
      chk($sformatf("pass3_acc%0d", k), aq[bp + k*2], (k != 0) ? 1 : 0);
    end

    // Drain stall: ofifo_valid low for 5 cycles right after the first psum write.
    begin
      int t = 0;
      snap();
      kick(2, 1, 0, 0, 10);
      while (!(inst[33] == 1'b0 && inst[32] == 1'b0) && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) chk("stall_reach", 1, 0);
      ofifo_valid = 1'b0;
      for (int s = 1; s <= 5; s++) begin
        @(negedge clk);
        chk($sformatf("stall_cen%0d", s), inst[33], 1);
        chk($sformatf("stall_ofrd%0d", s), inst[6], 0);
      end
      ofifo_valid = 1'b1;
      @(negedge clk);
      chk("stall_resume_ofrd", inst[6], 1);
      chk("stall_resume_cen", inst[33], 0);
      chk("stall_resume_addr", inst[31:21], 11);
      wait_done("stall");
      chk("stall_pwr", m_pwr - b_pwr, 2);
      chk("stall_pa0", pq[bp], 10);
      chk("stall_pa1", pq[bp + 1], 11);
    end

    // Abort mid-EXEC, then rerun the same job from scratch.
    begin
      int t = 0;
      snap();
      kick(4, 1, 0, 16, 0);
      while (!inst[1] && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) chk("abort_reach", 1, 0);
      reset = 1'b0;
      #1;
      chk("abort_inst", inst, IdleC);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_rel_inst", inst, IdleC);
      chk("abort_rel_busy", busy, 0);
      run_case("rerun", tbl[0]);
      for (int i = 0; i < 8; i++) chk($sformatf("rerun_w%0d", i), xq[bx + i], i);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rerun_x%0d", i), xq[bx + 8 + i], 16 + i);
        chk($sformatf("rerun_p%0d", i), pq[bp + i], i);
        chk($sformatf("rerun_acc%0d", i), aq[bp + i], 0);
      end
    end

    // Address wrap on both xmem and pmem.
    begin
      logic [10:0] exp_x[10];
      exp_x = '{2044, 2045, 2046, 2047, 0, 1, 2, 3, 2047, 0};
      snap();
      kick(2, 1, 2044, 2047, 2047);
      wait_done("wrap");
      chk("wrap_xrd", m_xrd - b_xrd, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("wrap_x%0d", i), xq[bx + i], exp_x[i]);
      chk("wrap_p0", pq[bp], 2047);
      chk("wrap_p1", pq[bp + 1], 0);
    end

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
